// File: rtl/mult_issue_ctrl_if.sv
// Handshake bundle between the pipeline, the mult unit and mult_issue_ctrl.
// The master modport is the controller's view; slave is the surrounding environment.
interface mult_issue_ctrl_if;
  // Pipeline request side
  logic        req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_tag;
  logic        req_ready;
  logic        flush;

  // mult unit side
  logic        mult_enable;
  logic [31:0] mult_multiplicand;
  logic [31:0] mult_multiplier;
  logic        mult_ready;
  logic [31:0] mult_result;
  logic        mult_exception;

  // Writeback response side
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic        rsp_exception;
  logic [4:0]  rsp_tag;
  logic        rsp_timeout;
  logic        rsp_accept;
  logic        stall;

  modport master (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_tag,
    output req_ready,
    input  flush,
    output mult_enable,
    output mult_multiplicand,
    output mult_multiplier,
    input  mult_ready,
    input  mult_result,
    input  mult_exception,
    output rsp_valid,
    output rsp_result,
    output rsp_exception,
    output rsp_tag,
    output rsp_timeout,
    input  rsp_accept,
    output stall
  );

  modport slave (
    output req_valid,
    output req_a,
    output req_b,
    output req_tag,
    input  req_ready,
    output flush,
    input  mult_enable,
    input  mult_multiplicand,
    input  mult_multiplier,
    output mult_ready,
    output mult_result,
    output mult_exception,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_exception,
    input  rsp_tag,
    input  rsp_timeout,
    output rsp_accept,
    input  stall
  );
endinterface

// File: rtl/mult_issue_ctrl.sv
// Issue/complete sequencer for the mult unit: latches a request, pulses enable, waits for ready,
// holds the response until writeback takes it. Optional watchdog enabled by MULT_TIMEOUT_EN.
module mult_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              resetn,
  mult_issue_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StDrain,
    StResp
  } state_e;

  state_e state_q, state_d;

  logic [31:0] a_q, b_q;
  logic [4:0]  tag_q;
  logic [31:0] res_q;
  logic        exc_q;
  logic        timeout_q;

  logic accept;
  logic capture;
  logic fire;
  logic wait_expired;

`ifdef MULT_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign wait_expired = (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  // Counter restarts on WAIT->DRAIN so the drain gets its own full timeout window.
  always_comb begin
    cnt_d = cnt_q;
    unique case (state_q)
      StIssue: cnt_d = 8'd0;
      StWait: begin
        if (bus.flush && !bus.mult_ready) begin
          cnt_d = 8'd0;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDrain: begin
        if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;

  assign wait_expired = 1'b0;
  assign unused_cfg   = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && !bus.flush) begin
          accept  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // The enable pulse goes out regardless; a flush here only diverts to DRAIN.
        state_d = bus.flush ? StDrain : StWait;
      end
      StWait: begin
        if (bus.flush) begin
          state_d = bus.mult_ready ? StIdle : StDrain;
        end else if (bus.mult_ready) begin
          capture = 1'b1;
          state_d = StResp;
        end else if (wait_expired) begin
          fire    = 1'b1;
          state_d = StResp;
        end
      end
      StDrain: begin
        if (bus.mult_ready || wait_expired) begin
          state_d = StIdle;
        end
      end
      StResp: begin
        if (bus.flush || bus.rsp_accept) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      tag_q     <= 5'd0;
      res_q     <= 32'd0;
      exc_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= bus.req_a;
        b_q   <= bus.req_b;
        tag_q <= bus.req_tag;
      end
      if (capture) begin
        res_q     <= bus.mult_result;
        exc_q     <= bus.mult_exception;
        timeout_q <= 1'b0;
      end else if (fire) begin
        res_q     <= 32'd0;
        exc_q     <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  // All control outputs decode the registered state, so reset clears them asynchronously.
  assign bus.req_ready         = (state_q == StIdle);
  assign bus.stall             = (state_q != StIdle);
  assign bus.mult_enable       = (state_q == StIssue);
  assign bus.rsp_valid         = (state_q == StResp);
  assign bus.mult_multiplicand = a_q;
  assign bus.mult_multiplier   = b_q;
  assign bus.rsp_result        = res_q;
  assign bus.rsp_exception     = exc_q;
  assign bus.rsp_tag           = tag_q;
`ifdef MULT_TIMEOUT_EN
  assign bus.rsp_timeout       = timeout_q;
`else
  assign bus.rsp_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: vector table of full transactions plus flush/reset/timeout
// sequences. Timeout checks are built only when MULT_TIMEOUT_EN is defined.
module tb_mult_issue_ctrl;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mult_issue_ctrl_if bus ();

  mult_issue_ctrl #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    int          lat;
    logic [31:0] m_res;
    logic        m_exc;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid      = 1'b0;
    bus.req_a          = 32'd0;
    bus.req_b          = 32'd0;
    bus.req_tag        = 5'd0;
    bus.flush          = 1'b0;
    bus.mult_ready     = 1'b0;
    bus.mult_result    = 32'd0;
    bus.mult_exception = 1'b0;
    bus.rsp_accept     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string where);
    chk({where, "_req_ready"}, bus.req_ready, 1);
    chk({where, "_stall"}, bus.stall, 0);
    chk({where, "_enable"}, bus.mult_enable, 0);
    chk({where, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({where, "_rsp_result"}, bus.rsp_result, 0);
    chk({where, "_rsp_exc"}, bus.rsp_exception, 0);
    chk({where, "_rsp_tag"}, bus.rsp_tag, 0);
    chk({where, "_rsp_timeout"}, bus.rsp_timeout, 0);
    chk({where, "_operand_a"}, bus.mult_multiplicand, 0);
    chk({where, "_operand_b"}, bus.mult_multiplier, 0);
  endtask

  // Request driven in the current cycle (N); returns in cycle N+1 (ISSUE).
  task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    tick();
    bus.req_valid = 1'b0;
    bus.req_a     = ~a;
    bus.req_b     = ~b;
    bus.req_tag   = ~tag;
  endtask

  task automatic run_txn(input vec_t v);
    int extra_en  = 0;
    int early_rsp = 0;
    int low_stall = 0;
    int op_bad    = 0;
    chk("txn_req_ready_idle", bus.req_ready, 1);
    send_req(v.a, v.b, v.tag);
    chk("txn_enable_issue", bus.mult_enable, 1);
    chk("txn_stall_issue", bus.stall, 1);
    chk("txn_req_ready_busy", bus.req_ready, 0);
    for (int i = 1; i <= v.lat; i++) begin
      tick();
      if (bus.mult_enable !== 1'b0) extra_en++;
      if (bus.rsp_valid !== 1'b0) early_rsp++;
      if (bus.stall !== 1'b1) low_stall++;
      if (bus.mult_multiplicand !== v.a || bus.mult_multiplier !== v.b) op_bad++;
      if (i == v.lat) begin
        bus.mult_ready     = 1'b1;
        bus.mult_result    = v.m_res;
        bus.mult_exception = v.m_exc;
      end
    end
    tick();
    bus.mult_ready     = 1'b0;
    bus.mult_result    = 32'hBAD0BAD0;
    bus.mult_exception = ~v.m_exc;
    chk("txn_extra_enable", extra_en, 0);
    chk("txn_early_rsp", early_rsp, 0);
    chk("txn_stall_wait", low_stall, 0);
    chk("txn_operands_stable", op_bad, 0);
    chk("txn_rsp_valid", bus.rsp_valid, 1);
    chk("txn_rsp_result", bus.rsp_result, v.exp_res);
    chk("txn_rsp_exc", bus.rsp_exception, v.exp_exc);
    chk("txn_rsp_tag", bus.rsp_tag, v.tag);
    chk("txn_rsp_timeout", bus.rsp_timeout, 0);
    chk("txn_stall_resp", bus.stall, 1);
    tick();
    chk("txn_rsp_hold_valid", bus.rsp_valid, 1);
    chk("txn_rsp_hold_result", bus.rsp_result, v.exp_res);
    bus.rsp_accept = 1'b1;
    tick();
    bus.rsp_accept     = 1'b0;
    bus.mult_exception = 1'b0;
    chk("txn_req_ready_after", bus.req_ready, 1);
    chk("txn_stall_after", bus.stall, 0);
    chk("txn_rsp_valid_after", bus.rsp_valid, 0);
    chk("txn_operand_hold_idle", bus.mult_multiplicand, v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int bad;
    vecs[0] = '{a: 32'd78, b: 32'd13, tag: 5'd5, lat: 8, m_res: 32'd1014, m_exc: 1'b0,
                exp_res: 32'h000003F6, exp_exc: 1'b0};
    vecs[1] = '{a: 32'h7FFFFFFF, b: 32'h7FFFFFFF, tag: 5'd17, lat: 3, m_res: 32'h00000001,
                m_exc: 1'b1, exp_res: 32'h00000001, exp_exc: 1'b1};
    vecs[2] = '{a: 32'hFFFFFFFF, b: 32'd2, tag: 5'd31, lat: 1, m_res: 32'hFFFFFFFE, m_exc: 1'b1,
                exp_res: 32'hFFFFFFFE, exp_exc: 1'b1};
    vecs[3] = '{a: 32'd0, b: 32'd123, tag: 5'd0, lat: 2, m_res: 32'd0, m_exc: 1'b0,
                exp_res: 32'h00000000, exp_exc: 1'b0};

    clear_inputs();
    #1;
    chk_reset_outputs("por");
    #7 resetn = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Stale ready in IDLE must not start anything.
    bus.mult_ready = 1'b1;
    tick();
    bus.mult_ready = 1'b0;
    chk("idle_ready_rsp_valid", bus.rsp_valid, 0);
    chk("idle_ready_stall", bus.stall, 0);

    // Flush together with a request in IDLE blocks acceptance.
    bus.flush = 1'b1;
    send_req(32'd9, 32'd9, 5'd9);
    bus.flush = 1'b0;
    chk("idle_flush_no_issue", bus.mult_enable, 0);
    chk("idle_flush_req_ready", bus.req_ready, 1);

    // Flush in the 3rd WAIT cycle, ready 4 cycles later.
    send_req(32'd5, 32'd6, 5'd3);
    tick();
    tick();
    tick();
    bus.flush = 1'b1;
    bad = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.flush = 1'b0;
      if (bus.stall !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) bad++;
      if (i == 4) begin
        bus.mult_ready  = 1'b1;
        bus.mult_result = 32'd30;
      end
    end
    tick();
    bus.mult_ready = 1'b0;
    chk("drain_busy_cycles", bad, 0);
    chk("drain_req_ready_after", bus.req_ready, 1);
    chk("drain_no_rsp", bus.rsp_valid, 0);
    run_txn(vecs[0]);

    // Flush and ready in the same WAIT cycle.
    send_req(32'd7, 32'd8, 5'd4);
    tick();
    bus.flush       = 1'b1;
    bus.mult_ready  = 1'b1;
    bus.mult_result = 32'hDEAD;
    tick();
    bus.flush      = 1'b0;
    bus.mult_ready = 1'b0;
    chk("flush_ready_idle", bus.req_ready, 1);
    chk("flush_ready_no_rsp", bus.rsp_valid, 0);
    chk("flush_ready_stall", bus.stall, 0);

    // Flush during ISSUE: pulse still emitted, then DRAIN until ready.
    send_req(32'd1, 32'd2, 5'd6);
    chk("issue_flush_enable", bus.mult_enable, 1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("issue_flush_drain_stall", bus.stall, 1);
    chk("issue_flush_drain_enable", bus.mult_enable, 0);
    chk("issue_flush_drain_rsp", bus.rsp_valid, 0);
    bus.mult_ready = 1'b1;
    tick();
    bus.mult_ready = 1'b0;
    chk("issue_flush_idle", bus.req_ready, 1);

    // Flush in RESP beats accept and drops the response.
    send_req(32'd3, 32'd4, 5'd8);
    tick();
    bus.mult_ready  = 1'b1;
    bus.mult_result = 32'd77;
    tick();
    bus.mult_ready = 1'b0;
    chk("resp_flush_valid_before", bus.rsp_valid, 1);
    bus.flush      = 1'b1;
    bus.rsp_accept = 1'b1;
    tick();
    bus.flush      = 1'b0;
    bus.rsp_accept = 1'b0;
    chk("resp_flush_dropped", bus.rsp_valid, 0);
    chk("resp_flush_idle", bus.req_ready, 1);

    // Asynchronous reset during WAIT.
    send_req(32'h11, 32'h22, 5'd9);
    tick();
    #2 resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_wait");
    #3 resetn = 1'b1;
    tick();

    // Asynchronous reset during RESP.
    send_req(32'h33, 32'h44, 5'd10);
    tick();
    bus.mult_ready     = 1'b1;
    bus.mult_result    = 32'h55;
    bus.mult_exception = 1'b1;
    tick();
    clear_inputs();
    chk("rst_resp_valid_before", bus.rsp_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk_reset_outputs("rst_resp");
    #3 resetn = 1'b1;
    tick();
    run_txn(vecs[1]);

`ifdef MULT_TIMEOUT_EN
    // Watchdog: ready never arrives, response after 16 WAIT cycles.
    send_req(32'd12, 32'd34, 5'd21);
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.stall !== 1'b1) bad++;
    end
    tick();
    chk("to_wait_cycles", bad, 0);
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_result", bus.rsp_result, 0);
    chk("to_rsp_exc", bus.rsp_exception, 1);
    chk("to_rsp_timeout", bus.rsp_timeout, 1);
    chk("to_rsp_tag", bus.rsp_tag, 21);
    bus.rsp_accept = 1'b1;
    tick();
    bus.rsp_accept  = 1'b0;
    bus.mult_ready  = 1'b1;
    bus.mult_result = 32'h99;
    tick();
    bus.mult_ready = 1'b0;
    chk("to_late_ready_rsp", bus.rsp_valid, 0);
    chk("to_late_ready_idle", bus.req_ready, 1);

    // DRAIN gives up after the same window.
    send_req(32'd1, 32'd1, 5'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    for (int i = 1; i < 16; i++) tick();
    chk("to_drain_busy", bus.req_ready, 0);
    tick();
    chk("to_drain_exit", bus.req_ready, 1);
    run_txn(vecs[2]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
